// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite register slave: response codes and FSM states.
package axi_lite_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {W_COLLECT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP}    rstate_t;

  // Byte-lane merge: lanes with strb set take the new data.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_regfile.sv
// Register storage: byte-strobed write port, combinational read of pre-edge contents.
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int NUM_REGS = 4,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic [IDX_W-1:0] ridx,
  output logic [31:0]      rdata
);

  logic [NUM_REGS-1:0][31:0] regs;
  logic [NUM_REGS-1:0]       sel;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_sel
    assign sel[r] = we && (widx == IDX_W'(r));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++)
        if (sel[i]) regs[i] <= strb_merge(regs[i], wdata, wstrb);
    end
  end

  assign rdata = regs[ridx];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite leaf slave: NUM_REGS x 32-bit registers, independent write/read FSMs,
// SLVERR on addresses beyond the register window.
module axi_lite_slave_regs
  import axi_lite_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready
);

  localparam int IDX_W = $clog2(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:2+IDX_W] == '0;
  endfunction

  wstate_t wstate, wstate_nxt;
  rstate_t rstate, rstate_nxt;

  logic                aw_held, w_held;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wstrb_q;
  axi_resp_t           bresp_q, rresp_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [31:0]         rf_rdata;

  logic aw_hs, w_hs, ar_hs, commit;

  assign awready = !rst && !aw_held;
  assign wready  = !rst && !w_held;
  assign arready = !rst && (rstate == R_IDLE);
  assign bvalid  = (wstate == W_RESP);
  assign rvalid  = (rstate == R_RESP);
  assign bresp   = bresp_q;
  assign rresp   = rresp_q;
  assign rdata   = rdata_q;

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  // A pair collected while B is outstanding waits until the B handshake retires.
  assign commit = aw_held && w_held && (wstate == W_COLLECT);

  // Address bits [1:0] carry no meaning for word registers.
  logic unused_lsbs;
  assign unused_lsbs = ^{awaddr[1:0], araddr[1:0], aw_addr_q[1:0]};

  // ---------------- write path ----------------
  always_comb begin
    wstate_nxt = wstate;
    case (wstate)
      W_COLLECT: if (commit) wstate_nxt = W_RESP;
      W_RESP:    if (bready) wstate_nxt = W_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate  <= W_COLLECT;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp_q <= RESP_OKAY;
    end else begin
      wstate <= wstate_nxt;
      if (aw_hs)       aw_held <= 1'b1;
      else if (commit) aw_held <= 1'b0;
      if (w_hs)        w_held  <= 1'b1;
      else if (commit) w_held  <= 1'b0;
      if (commit) bresp_q <= in_range(aw_addr_q) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= awaddr;
    if (w_hs) begin
      wdata_q <= wdata;
      wstrb_q <= wstrb;
    end
  end

  axi_lite_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
    .clk   (clk),
    .rst   (rst),
    .we    (commit && in_range(aw_addr_q)),
    .widx  (aw_addr_q[2 +: IDX_W]),
    .wdata (wdata_q),
    .wstrb (wstrb_q),
    .ridx  (araddr[2 +: IDX_W]),
    .rdata (rf_rdata)
  );

  // ---------------- read path ----------------
  always_comb begin
    rstate_nxt = rstate;
    case (rstate)
      R_IDLE: if (ar_hs)  rstate_nxt = R_RESP;
      R_RESP: if (rready) rstate_nxt = R_IDLE;
    endcase
  end

  // rf_rdata is the pre-edge value, so a same-edge commit is not observed here.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate  <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      rstate <= rstate_nxt;
      if (ar_hs) begin
        rdata_q <= in_range(araddr) ? rf_rdata : '0;
        rresp_q <= in_range(araddr) ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Randomized + directed bench for axi_lite_slave_regs against an array-based register model.
module tb_axi_lite_slave_regs;
  import axi_lite_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int NUM_REGS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [NUM_REGS];

  always #5 clk = ~clk;

  axi_lite_slave_regs #(.ADDR_W(ADDR_W), .DATA_W(32), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Reference model: registers occupy bytes [0, 4*NUM_REGS); anything else is an error.
  function automatic bit m_ok(input logic [31:0] a);
    return a < 32'(NUM_REGS * 4);
  endfunction
  function automatic int m_idx(input logic [31:0] a);
    return int'(a / 4) % NUM_REGS;
  endfunction
  function automatic logic [1:0] m_resp(input logic [31:0] a);
    return m_ok(a) ? 2'b00 : 2'b10;
  endfunction
  function automatic logic [31:0] m_read(input logic [31:0] a);
    return m_ok(a) ? model[m_idx(a)] : 32'h0;
  endfunction
  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (m_ok(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) model[m_idx(a)][8*b +: 8] = d[8*b +: 8];
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drives AW and W with independent start delays; returns at the negedge after the later handshake.
  task automatic send_aw_w(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int c = 0;
    while (!(aw_done && w_done) && c < 60) begin
      awaddr  = a;
      wdata   = d;
      wstrb   = s;
      awvalid = !aw_done && (c >= aw_dly);
      wvalid  = !w_done && (c >= w_dly);
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      cyc();
      if (aw_fire) aw_done = 1;
      if (w_fire)  w_done = 1;
      c++;
      if (w_done && !aw_done) chk("wready_held", wready, 0);
      if (aw_done && !w_done) chk("awready_held", awready, 0);
    end
    awvalid = 0;
    wvalid  = 0;
    if (!(aw_done && w_done)) chk("aw_w_timeout", 0, 1);
  endtask

  task automatic take_b(input logic [1:0] exp_resp, input int hold);
    int n = 0;
    while (!bvalid && n < 50) begin cyc(); n++; end
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, exp_resp);
    repeat (hold) begin
      cyc();
      chk("bvalid_stable", bvalid, 1);
      chk("bresp_stable", bresp, exp_resp);
    end
    bready = 1;
    cyc();
    bready = 0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int aw_dly, input int w_dly, input int hold);
    send_aw_w(a, d, s, aw_dly, w_dly);
    chk("b_early", bvalid, 0);
    cyc();
    chk("b_latency", bvalid, 1);
    take_b(m_resp(a), hold);
    m_write(a, d, s);
  endtask

  task automatic rd(input logic [31:0] a, input int hold);
    logic [31:0] exp_d;
    int n = 0;
    exp_d   = m_read(a);
    arvalid = 1;
    araddr  = a;
    while (!arready && n < 50) begin cyc(); n++; end
    cyc();
    arvalid = 0;
    chk("rvalid", rvalid, 1);
    chk("rdata", rdata, exp_d);
    chk("rresp", rresp, m_resp(a));
    repeat (hold) begin
      cyc();
      chk("rvalid_stable", rvalid, 1);
      chk("rdata_stable", rdata, exp_d);
      chk("arready_busy", arready, 0);
    end
    rready = 1;
    cyc();
    rready = 0;
    chk("arready_back", arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, prev;
    rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 0;

    // reset state
    repeat (2) cyc();
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    rst = 0;
    repeat (2) cyc();
    chk("idle_awready", awready, 1);
    chk("idle_arready", arready, 1);

    // full-word write, AW and W together
    wr(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    rd(32'h4, 0);

    // partial strobe
    wr(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    wr(32'h8, 32'h00AB0000, 4'b0100, 0, 0, 0);
    rd(32'h8, 0);

    // W three cycles ahead of AW
    wr(32'hC, 32'h12345678, 4'hF, 3, 0, 0);
    rd(32'hC, 0);

    // out of range
    wr(32'h40, 32'h1, 4'hF, 0, 0, 0);
    rd(32'h40, 0);
    for (int i = 0; i < NUM_REGS; i++) rd(32'(4 * i), 0);

    // back-pressure: second write pending behind an unacknowledged B
    send_aw_w(32'h0, 32'hA5A50001, 4'hF, 0, 0);
    cyc();
    chk("bp_b1", bvalid, 1);
    m_write(32'h0, 32'hA5A50001, 4'hF);
    send_aw_w(32'h0, 32'h5A5A0002, 4'hF, 0, 0);
    repeat (5) begin
      cyc();
      chk("bp_bvalid", bvalid, 1);
      chk("bp_bresp", bresp, 2'b00);
    end
    rd(32'h0, 4);
    chk("bp_still", bvalid, 1);
    bready = 1;
    cyc();
    bready = 0;
    chk("bp_gap", bvalid, 0);
    cyc();
    chk("bp_b2", bvalid, 1);
    take_b(2'b00, 0);
    m_write(32'h0, 32'h5A5A0002, 4'hF);
    rd(32'h0, 0);

    // same-edge commit and AR on one register
    prev = m_read(32'h4);
    awaddr = 32'h4; wdata = 32'hCAFEF00D; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    cyc();
    awvalid = 0; wvalid = 0; araddr = 32'h4; arvalid = 1;
    cyc();
    arvalid = 0;
    chk("se_rvalid", rvalid, 1);
    chk("se_old", rdata, prev);
    chk("se_bvalid", bvalid, 1);
    rready = 1; cyc(); rready = 0;
    take_b(2'b00, 0);
    m_write(32'h4, 32'hCAFEF00D, 4'hF);
    rd(32'h4, 0);

    // reset one cycle after AW, before W
    awaddr = 32'h8; awvalid = 1;
    cyc();
    awvalid = 0; rst = 1;
    #1;
    chk("mr_awready", awready, 0);
    chk("mr_wready", wready, 0);
    cyc();
    rst = 0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 0;
    repeat (3) begin
      cyc();
      chk("mr_no_b", bvalid, 0);
    end
    for (int i = 0; i < NUM_REGS; i++) rd(32'(4 * i), 0);
    wr(32'h8, 32'h00000077, 4'hF, 1, 0, 0);
    rd(32'h8, 0);

    // randomized traffic
    for (int it = 0; it < 80; it++) begin
      a = ($urandom_range(0, 4) == 0) ? $urandom : 32'($urandom_range(0, 4 * NUM_REGS - 1));
      d = $urandom;
      if ($urandom_range(0, 1) == 0)
        wr(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 2));
      else
        rd(a, $urandom_range(0, 2));
    end
    for (int i = 0; i < NUM_REGS; i++) rd(32'(4 * i), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
- AXI4-Lite responder: a bank of NUM_REGS 32-bit read/write registers, with write-byte strobes and a decode error response.
- It is the DUT-side counterpart of the team's axi_write/axi_read bench tasks.
- The AW, W, B, AR and R channels are all supported; there is no burst, ID or prot handling.
- It sits behind the bench master or an interconnect as a leaf peripheral.

Parameters:
- ADDR_W, 32, width of awaddr/araddr.
- DATA_W, 32, data width; fixed to 32 (wstrb is 4 bits).
- NUM_REGS, 4, number of registers; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- awaddr  in  ADDR_W  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data.
- wstrb  in  4  byte strobes; bit i enables wdata[8i+7:8i].
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_W  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rresp  out  2  read response.
- rvalid  out  1  read response valid.
- rready  in  1  read response ready.

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - All registers become 0.
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0.
  - aw_held=0, w_held=0.
  - awready, wready and arready are forced to 0 combinationally while rst=1.
  - Reset asserted mid-transaction abandons it: no B or R response is issued and no register is updated at that edge.
- Decode:
  - idx = addr[2 +: log2(NUM_REGS)].
  - The address is in range iff addr[ADDR_W-1:2+log2(NUM_REGS)] == 0.
  - addr[1:0] is ignored (no alignment error).
- Write path (states W_COLLECT, W_RESP):
  - awready = !rst && !aw_held.
  - wready = !rst && !w_held.
  - An AW handshake (awvalid && awready at posedge) latches the address and sets aw_held.
  - A W handshake latches wdata/wstrb and sets w_held.
  - AW and W are independent; either order, or the same cycle, is legal.
  - Commit happens at the posedge where aw_held && w_held && !bvalid. At that edge:
    - in range: each byte with wstrb set is written; bresp=OKAY (2'b00).
    - out of range: no write; bresp=SLVERR (2'b10).
    - bvalid is set, and aw_held and w_held are cleared.
  - bvalid therefore rises one cycle after the later of the two handshakes.
  - bvalid and bresp hold stable until bvalid && bready at a posedge, which clears bvalid.
  - bready may arrive any number of cycles late.
  - While bvalid=1, a new AW/W pair may be accepted but does not commit until the B handshake completes; it commits at the earliest on the edge after bvalid clears.
- Read path (states R_IDLE, R_RESP):
  - arready = !rst && !rvalid.
  - At the AR handshake edge:
    - rdata is loaded with regs[idx] in range (rresp=OKAY), or 0 out of range (rresp=SLVERR).
    - rvalid is set.
  - rvalid, rdata and rresp hold until rvalid && rready, which clears rvalid.
  - arready returns to 1 in the following cycle.
- Same-edge read/write:
  - If a write commit and an AR handshake hit the same register on the same edge, rdata returns the old value.
  - The new value is visible to the next read.
- Read and write channels operate concurrently with no mutual blocking.

Decomposition:
- Package axi_lite_pkg holds:
  - typedef logic [1:0] axi_resp_t;
  - RESP_OKAY = 2'b00;
  - RESP_SLVERR = 2'b10;
  - state enums for the write FSM (W_COLLECT, W_RESP) and read FSM (R_IDLE, R_RESP).
- Sub-module axi_lite_regfile holds storage only:
  - inputs: clk, rst, we, widx, wdata, wstrb, ridx.
  - output: rdata, a combinational read of the pre-edge contents.
  - Top level keeps both FSMs, the holding registers and the decode.

Test Plan:
- Write 0x10 ← 0xDEADBEEF? No: write addr 0x4 ← 0xDEADBEEF, wstrb 4'hF, AW and W driven in the same cycle; then read 0x4 -> bvalid one cycle after the handshake, bresp=00; rdata=0xDEADBEEF, rresp=00.
- Partial strobe: write 0x8 ← 0xFFFFFFFF, then write 0x8 ← 0x00AB0000 with wstrb 4'b0100 -> read 0x8 returns 0xFFABFFFF.
- Decoupled channels: W driven 3 cycles before AW, addr 0xC, data 0x12345678 -> wready drops after the W handshake, commit occurs one cycle after the AW handshake, read 0xC returns 0x12345678.
- Out of range: write 0x40 ← 0x1, then read 0x40 -> bresp=10 and rresp=10, rdata=0; reads of 0x0-0xC are unchanged.
- Back-pressure: bready held low 5 cycles with a second write pending -> bvalid and bresp stable throughout; second commit occurs only after the B handshake; rready held low 4 cycles -> rvalid and rdata stable, arready=0.
- Reset mid-write: assert rst one cycle after the AW handshake, before W -> no bvalid; all registers read back 0; a fresh write after reset completes normally.
